// File: rtl/reg_file.sv
// reg_file: single-port synchronous register file.
//
// DEPTH words of WIDTH bits sharing one address for reads and writes.
// Reads are registered: rddata updates on the edge that samples rden and
// otherwise holds its last value. A simultaneous write and read to the
// shared address returns the new data (write-first).
//
// Ports:
//   clk      rising-edge clock for all state
//   rst      synchronous, active-high reset; clears every word and rddata
//   wren     write enable
//   rden     read enable
//   address  shared word address, $clog2(DEPTH) bits
//   wrdata   write data, WIDTH bits
//   rddata   registered read data, WIDTH bits
//
// Addresses at or above DEPTH (reachable only when DEPTH is not a power of
// two) drop writes and read back as zero.

module reg_file #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wren,
   input  logic                     rden,
   input  logic [$clog2(DEPTH)-1:0] address,
   input  logic [WIDTH-1:0]         wrdata,
   output logic [WIDTH-1:0]         rddata
);

   localparam int unsigned AW = $clog2(DEPTH);

   // One extra bit so DEPTH itself is representable when it is a power of two.
   localparam logic [AW:0] DepthLim = DEPTH[AW:0];

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rddata_q;
   logic             in_range;

   assign in_range = ({1'b0, address} < DepthLim);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
         rddata_q <= '0;
      end else begin
         if (wren && in_range) begin
            mem_q[address] <= wrdata;
         end
         if (rden) begin
            if (!in_range) begin
               rddata_q <= '0;
            end else if (wren) begin
               // Write-first: forward the incoming word instead of the stale one.
               rddata_q <= wrdata;
            end else begin
               rddata_q <= mem_q[address];
            end
         end
      end
   end

   assign rddata = rddata_q;

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: randomized, scoreboard-checked bench for reg_file.
//
// Two instances share one stimulus stream: DEPTH=8 (full address space) and
// DEPTH=6 (addresses 6 and 7 out of range). Every driven cycle pushes the
// expected rddata after that edge into a per-instance queue; a monitor pops
// and compares one entry per rising edge.

module tb_reg_file;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wren = 1'b0;
   logic        rden = 1'b0;
   logic [2:0]  address = '0;
   logic [15:0] wrdata = '0;
   logic [15:0] rd8;
   logic [15:0] rd6;

   always #5 clk = ~clk;

   reg_file #(.WIDTH(16), .DEPTH(8)) dut8 (
      .clk     (clk),
      .rst     (rst),
      .wren    (wren),
      .rden    (rden),
      .address (address),
      .wrdata  (wrdata),
      .rddata  (rd8)
   );

   reg_file #(.WIDTH(16), .DEPTH(6)) dut6 (
      .clk     (clk),
      .rst     (rst),
      .wren    (wren),
      .rden    (rden),
      .address (address),
      .wrdata  (wrdata),
      .rddata  (rd6)
   );

   // Reference model: plain storage arrays plus last read value per instance.
   int          depth [2] = '{8, 6};
   logic [15:0] m [2][8];
   logic [15:0] r_m [2];
   logic [15:0] q8 [$];
   logic [15:0] q6 [$];

   int n_checks = 0;
   int n_fail   = 0;

   function automatic void check(input string name, input logic [15:0] act,
                                 input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endfunction

   // Drive one cycle away from the active edge and record what rddata must be
   // after the following rising edge.
   task automatic cycle(input logic r, input logic we, input logic re,
                        input logic [2:0] a, input logic [15:0] d);
      logic [15:0] nr;
      @(negedge clk);
      rst = r; wren = we; rden = re; address = a; wrdata = d;
      for (int k = 0; k < 2; k++) begin
         nr = r_m[k];
         if (r) begin
            for (int i = 0; i < 8; i++) m[k][i] = 16'h0;
            nr = 16'h0;
         end else begin
            if (re) nr = (int'(a) >= depth[k]) ? 16'h0 : (we ? d : m[k][a]);
            if (we && int'(a) < depth[k]) m[k][a] = d;
         end
         r_m[k] = nr;
         if (k == 0) q8.push_back(nr);
         else        q6.push_back(nr);
      end
   endtask

   // Monitor: rddata is presented every edge once stimulus is running.
   initial begin
      logic [15:0] e;
      forever begin
         @(posedge clk);
         #1;
         if (q8.size() > 0) begin
            e = q8.pop_front();
            check("rddata_d8", rd8, e);
         end
         if (q6.size() > 0) begin
            e = q6.pop_front();
            check("rddata_d6", rd6, e);
         end
      end
   end

   initial begin
      // Reset clear, then sweep reads.
      cycle(1, 0, 0, 0, 16'h0);
      for (int i = 0; i < 8; i++) cycle(0, 0, 1, 3'(i), 16'h0);

      // Basic write/read; rddata must hold 0 during the writes.
      cycle(0, 1, 0, 0, 16'd50);
      cycle(0, 1, 0, 2, 16'd93);
      cycle(0, 0, 1, 0, 16'h0);
      cycle(0, 0, 1, 2, 16'h0);

      // Write-first, then plain readback.
      cycle(0, 1, 1, 2, 16'h1234);
      cycle(0, 0, 1, 2, 16'h0);

      // Hold while other locations change.
      cycle(0, 0, 1, 0, 16'h0);
      cycle(0, 1, 0, 5, 16'h5555);
      cycle(0, 1, 0, 1, 16'h1111);
      cycle(0, 0, 0, 7, 16'hDEAD);

      // Full sweep, readback, top-address boundary.
      for (int i = 0; i < 8; i++) cycle(0, 1, 0, 3'(i), 16'hA000 + 16'(i));
      for (int i = 0; i < 8; i++) cycle(0, 0, 1, 3'(i), 16'h0);
      cycle(0, 1, 0, 7, 16'hFFFF);
      cycle(0, 0, 1, 7, 16'h0);
      cycle(0, 0, 1, 6, 16'h0);
      // Out-of-range write-first on the DEPTH=6 instance must still read 0.
      cycle(0, 1, 1, 6, 16'hBEEF);

      // Reset beats a simultaneous write and read.
      cycle(1, 1, 1, 3, 16'd77);
      for (int i = 0; i < 8; i++) cycle(0, 0, 1, 3'(i), 16'h0);
      cycle(0, 1, 0, 3, 16'd77);
      cycle(0, 0, 1, 3, 16'h0);

      // Randomized traffic with occasional resets.
      for (int n = 0; n < 400; n++) begin
         cycle(($urandom_range(0, 39) == 0), 1'($urandom), 1'($urandom),
               3'($urandom_range(0, 7)), 16'($urandom));
      end

      // Let the monitor drain the last expected values.
      @(negedge clk);
      @(negedge clk);
      n_checks++;
      if (q8.size() != 0 || q6.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d/%0d pending expected 0/0",
                  q8.size(), q6.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
